// File: rtl/pfxsum_pkg.sv
// rtl/pfxsum_pkg.sv - shared defaults, state encoding and vector type for the pfxsum sequencer
package pfxsum_pkg;

    localparam int INT_WIDTH_DEF  = 32;
    localparam int V_LEN_DEF      = 8;
    localparam int ADDR_WIDTH_DEF = 10;
    localparam int TIMEOUT_DEF    = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_RD,
        S_ISSUE,
        S_WAIT_PFX,
        S_WRITE,
        S_DONE
    } state_t;

    typedef logic [INT_WIDTH_DEF*V_LEN_DEF-1:0] vec_t;

endpackage

// File: rtl/pfxsum_seq_if.sv
// rtl/pfxsum_seq_if.sv - host, vector memory and Pfxsum signals of the sequencer
interface pfxsum_seq_if import pfxsum_pkg::*; #(
    parameter int INT_WIDTH  = INT_WIDTH_DEF,
    parameter int V_LEN      = V_LEN_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                         start;
    logic [ADDR_WIDTH-1:0]        base;
    logic [ADDR_WIDTH-1:0]        len;
    logic                         busy;
    logic                         done;
    logic                         err;
    logic                         mem_rd_en;
    logic                         mem_wr_en;
    logic [ADDR_WIDTH-1:0]        mem_addr;
    logic [INT_WIDTH*V_LEN-1:0]   mem_rd_data;
    logic [INT_WIDTH*V_LEN-1:0]   mem_wr_data;
    logic                         pfx_valid_in;
    logic [INT_WIDTH*V_LEN-1:0]   pfx_ivec;
    logic                         pfx_valid_out;
    logic [INT_WIDTH*V_LEN-1:0]   pfx_ovec;

    modport master (
        input  start, base, len, mem_rd_data, pfx_valid_out, pfx_ovec,
        output busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
               pfx_valid_in, pfx_ivec
    );

    modport slave (
        output start, base, len, mem_rd_data, pfx_valid_out, pfx_ovec,
        input  busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wr_data,
               pfx_valid_in, pfx_ivec
    );

endinterface

// File: rtl/pfxsum_carry_add.sv
// rtl/pfxsum_carry_add.sv - lane-wise wrapping add of a scalar carry to a packed vector
module pfxsum_carry_add import pfxsum_pkg::*; #(
    parameter int INT_WIDTH = INT_WIDTH_DEF,
    parameter int V_LEN     = V_LEN_DEF
) (
    input  logic [INT_WIDTH*V_LEN-1:0] vec,
    input  logic [INT_WIDTH-1:0]       carry,
    output logic [INT_WIDTH*V_LEN-1:0] sum
);

    for (genvar i = 0; i < V_LEN; i++) begin : g_lane
        assign sum[i*INT_WIDTH +: INT_WIDTH] = vec[i*INT_WIDTH +: INT_WIDTH] + carry;
    end

endmodule

// File: rtl/pfxsum_seq.sv
// rtl/pfxsum_seq.sv - walks a vector array through Pfxsum and writes back an array-wide inclusive prefix sum
module pfxsum_seq import pfxsum_pkg::*; #(
    parameter int INT_WIDTH  = INT_WIDTH_DEF,
    parameter int V_LEN      = V_LEN_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    pfxsum_seq_if.master  bus
);

    localparam int VW   = INT_WIDTH * V_LEN;
    localparam int WD_W = $clog2(TIMEOUT + 1);

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  base_r;
    logic [ADDR_WIDTH-1:0]  len_r;
    logic [ADDR_WIDTH-1:0]  idx;
    logic [ADDR_WIDTH-1:0]  idx_nxt;
    logic [INT_WIDTH-1:0]   carry;
    logic [WD_W-1:0]        wd;
    logic [VW-1:0]          sum;

    assign idx_nxt = idx + ADDR_WIDTH'(1);

    pfxsum_carry_add #(
        .INT_WIDTH (INT_WIDTH),
        .V_LEN     (V_LEN)
    ) u_carry_add (
        .vec   (bus.pfx_ovec),
        .carry (carry),
        .sum   (sum)
    );

    // Every output is set on the transition into the state that owns it,
    // so the strobes line up with the state register cycle for cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            base_r           <= '0;
            len_r            <= '0;
            idx              <= '0;
            carry            <= '0;
            wd               <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.mem_rd_en    <= 1'b0;
            bus.mem_wr_en    <= 1'b0;
            bus.mem_addr     <= '0;
            bus.mem_wr_data  <= '0;
            bus.pfx_valid_in <= 1'b0;
            bus.pfx_ivec     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        base_r   <= bus.base;
                        len_r    <= bus.len;
                        idx      <= '0;
                        carry    <= '0;
                        bus.err  <= 1'b0;
                        bus.busy <= 1'b1;
                        if (bus.len != '0) begin
                            bus.mem_rd_en <= 1'b1;
                            bus.mem_addr  <= bus.base;
                            state         <= S_READ;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_READ: begin
                    bus.mem_rd_en <= 1'b0;
                    state         <= S_WAIT_RD;
                end
                S_WAIT_RD: begin
                    bus.pfx_ivec     <= bus.mem_rd_data;
                    bus.pfx_valid_in <= 1'b1;
                    state            <= S_ISSUE;
                end
                S_ISSUE: begin
                    bus.pfx_valid_in <= 1'b0;
                    wd               <= '0;
                    state            <= S_WAIT_PFX;
                end
                S_WAIT_PFX: begin
                    // A result arriving on the last watchdog cycle still wins.
                    if (bus.pfx_valid_out) begin
                        bus.mem_wr_en   <= 1'b1;
                        bus.mem_addr    <= base_r + idx;
                        bus.mem_wr_data <= sum;
                        state           <= S_WRITE;
                    end else if (wd == WD_W'(TIMEOUT - 1)) begin
                        bus.err <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        wd <= wd + WD_W'(1);
                    end
                end
                S_WRITE: begin
                    bus.mem_wr_en <= 1'b0;
                    carry         <= bus.mem_wr_data[VW-1 -: INT_WIDTH];
                    idx           <= idx_nxt;
                    if (idx_nxt == len_r) begin
                        state <= S_DONE;
                    end else begin
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= base_r + idx_nxt;
                        state         <= S_READ;
                    end
                end
                S_DONE: begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pfxsum_seq.sv
// tb/tb_pfxsum_seq.sv - scoreboard bench for pfxsum_seq with a memory model and a Pfxsum stub
module tb_pfxsum_seq;
    import pfxsum_pkg::*;

    localparam int IW    = 32;
    localparam int VL    = 8;
    localparam int AW    = 10;
    localparam int TO    = 10;
    localparam int VW    = IW * VL;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pfxsum_seq_if #(.INT_WIDTH(IW), .V_LEN(VL), .ADDR_WIDTH(AW)) bus ();

    pfxsum_seq #(
        .INT_WIDTH  (IW),
        .V_LEN      (VL),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] pfx(input logic [VW-1:0] v);
        logic [VW-1:0] r;
        logic [IW-1:0] acc;
        acc = '0;
        r   = '0;
        for (int i = 0; i < VL; i++) begin
            acc = acc + v[i*IW +: IW];
            r[i*IW +: IW] = acc;
        end
        return r;
    endfunction

    function automatic logic [VW-1:0] addc(input logic [VW-1:0] v, input logic [IW-1:0] c);
        logic [VW-1:0] r;
        for (int i = 0; i < VL; i++) r[i*IW +: IW] = v[i*IW +: IW] + c;
        return r;
    endfunction

    function automatic logic [VW-1:0] rvec();
        logic [VW-1:0] r;
        for (int i = 0; i < VL; i++) r[i*IW +: IW] = $urandom;
        return r;
    endfunction

    // Vector memory: one-cycle read latency, loads from the bench through ld_*.
    logic [VW-1:0] mem [DEPTH];
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_a  = '0;
    logic [VW-1:0] ld_d  = '0;

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wr_data;
        else if (ld_en)    mem[ld_a] <= ld_d;
    end

    // Pfxsum stub: in-vector inclusive scan after lat cycles; silent drops issues.
    typedef struct { int due; logic [VW-1:0] v; } pend_t;
    pend_t pq[$];
    int cyc = 0;
    int lat = 1;
    bit silent = 1'b0;

    always @(posedge clk) begin
        int now;
        pend_t p;
        now = cyc;
        cyc = cyc + 1;
        if (bus.pfx_valid_in && !silent) begin
            p.due = now + lat;
            p.v   = pfx(bus.pfx_ivec);
            pq.push_back(p);
        end
        if (pq.size() > 0 && pq[0].due == now + 1) begin
            bus.pfx_valid_out <= 1'b1;
            bus.pfx_ovec      <= pq[0].v;
            void'(pq.pop_front());
        end else begin
            bus.pfx_valid_out <= 1'b0;
        end
    end

    typedef struct { logic [AW-1:0] a; logic [VW-1:0] d; } wr_t;
    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    int n_rd = 0, n_wr = 0, n_iss = 0, n_done = 0;

    always @(negedge clk) begin
        wr_t w;
        if (rst_n) begin
            if (bus.mem_rd_en) begin
                n_rd++;
                chk("rd_wr_excl", bus.mem_wr_en, 0);
                if (rq.size() == 0) chk("rd_unexp", bus.mem_rd_en, 0);
                else chk("rd_addr", bus.mem_addr, rq.pop_front());
            end
            if (bus.mem_wr_en) begin
                n_wr++;
                if (wq.size() == 0) chk("wr_unexp", bus.mem_wr_en, 0);
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", bus.mem_addr, w.a);
                    chk("wr_data", bus.mem_wr_data, w.d);
                end
            end
            if (bus.pfx_valid_in) n_iss++;
            if (bus.done) n_done++;
        end
    end

    task automatic load(input logic [AW-1:0] a, input logic [VW-1:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_a = a; ld_d = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, 0);
        chk({tag, "_rd_en"}, bus.mem_rd_en, 0);
        chk({tag, "_wr_en"}, bus.mem_wr_en, 0);
        chk({tag, "_valid_in"}, bus.pfx_valid_in, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_wr_data"}, bus.mem_wr_data, 0);
        chk({tag, "_ivec"}, bus.pfx_ivec, 0);
    endtask

    task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] n, input int l, input bit exp_to);
        logic [IW-1:0] c;
        logic [AW-1:0] a;
        logic [VW-1:0] v;
        wr_t           w;
        int            t0, tdone, terr, exp_done;
        lat = l;
        c = '0;
        if (exp_to) rq.push_back(b);
        else begin
            for (int i = 0; i < int'(n); i++) begin
                a = b + AW'(i);
                rq.push_back(a);
                v = addc(pfx(mem[a]), c);
                w.a = a; w.d = v;
                wq.push_back(w);
                c = v[VW-1 -: IW];
            end
        end
        exp_done = exp_to ? TO + 5 : (n == 0 ? 2 : 2 + int'(n) * (4 + l));
        @(negedge clk);
        bus.start = 1'b1; bus.base = b; bus.len = n;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_c1", bus.busy, 1);
        chk("rd_en_c1", bus.mem_rd_en, n != 0);
        chk("err_c1", bus.err, 0);
        tdone = -1; terr = -1;
        for (int k = 0; k < 4000; k++) begin
            if (bus.err && terr < 0) terr = cyc - t0;
            if (bus.done) begin tdone = cyc - t0; break; end
            @(negedge clk);
        end
        chk("done_cyc", tdone, exp_done);
        chk("busy_at_done", bus.busy, 0);
        if (exp_to) chk("err_cyc", terr, TO + 4);
        else        chk("err_clear", bus.err, 0);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("err_sticky", bus.err, exp_to);
        chk("rd_queue_empty", rq.size(), 0);
        chk("wr_queue_empty", wq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [VW-1:0] ones, v0, saved;
        int rd0, wr0, iss0, done0, t0;
        logic [AW-1:0] b, n;

        for (int i = 0; i < VL; i++) ones[i*IW +: IW] = 1;
        bus.start = 1'b0; bus.base = '0; bus.len = '0;

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // Two vectors of ones: prefix across the array gives 1..16.
        load(0, ones); load(1, ones);
        done0 = n_done; iss0 = n_iss;
        run(0, 2, 1, 0);
        for (int i = 0; i < VL; i++) begin
            chk("s1_mem0_lane", mem[0][i*IW +: IW], i + 1);
            chk("s1_mem1_lane", mem[1][i*IW +: IW], i + 9);
        end
        chk("s1_done_count", n_done - done0, 1);
        chk("s1_issue_count", n_iss - iss0, 2);

        // Empty job: no strobes at all.
        rd0 = n_rd; wr0 = n_wr; iss0 = n_iss;
        run(5, 0, 1, 0);
        chk("len0_rd", n_rd - rd0, 0);
        chk("len0_wr", n_wr - wr0, 0);
        chk("len0_iss", n_iss - iss0, 0);

        // Address wrap from the last vector to vector 0.
        load(1023, rvec()); load(0, rvec());
        run(1023, 2, 3, 0);

        // Lane carry overflow wraps per lane.
        v0 = '0; v0[VW-1 -: IW] = 32'hFFFF_FFFF;
        load(0, v0); load(1, ones);
        run(0, 2, 2, 0);
        for (int i = 0; i < VL; i++) chk("ovf_mem1_lane", mem[1][i*IW +: IW], i);

        // Silent Pfxsum: timeout, no write-back.
        saved = rvec();
        load(20, saved);
        silent = 1'b1;
        wr0 = n_wr;
        run(20, 1, 1, 1);
        silent = 1'b0;
        chk("to_no_write", n_wr - wr0, 0);
        chk("to_mem_kept", mem[20], saved);

        // Reset during WAIT_PFX, late result lands while idle, then rerun.
        load(0, ones); load(1, ones);
        lat = 8;
        rq.push_back(0);
        @(negedge clk);
        bus.start = 1'b1; bus.base = 0; bus.len = 2;
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        while (cyc < t0 + 6) @(negedge clk);
        chk("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        while (cyc < t0 + 16) @(negedge clk);
        chk("stale_err", bus.err, 0);
        chk("stale_busy", bus.busy, 0);
        chk("abort_mem0", mem[0], ones);
        chk("abort_rq_empty", rq.size(), 0);
        run(0, 2, 1, 0);
        for (int i = 0; i < VL; i++) begin
            chk("rerun_mem0_lane", mem[0][i*IW +: IW], i + 1);
            chk("rerun_mem1_lane", mem[1][i*IW +: IW], i + 9);
        end

        // Random jobs.
        for (int j = 0; j < 3; j++) begin
            b = AW'($urandom_range(0, DEPTH - 1));
            n = AW'($urandom_range(1, 4));
            for (int i = 0; i < int'(n); i++) load(b + AW'(i), rvec());
            run(b, n, $urandom_range(1, 4), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
